cla_adder_pipe: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- Operand width is split into STAGES equal segments. Each segment is built from BLOCK-bit CLA blocks with a rippled group carry.
- The inter-segment carry is registered, so one result is accepted per cycle at a fixed latency of STAGES cycles.
- Serves as the datapath adder for multi-cycle ALU and accumulator blocks where a full-width combinational adder misses timing.

---
 rtl/cla_pkg.sv | 24 ++
 rtl/cla_adder_pipe_block.sv | 42 ++++
 rtl/cla_adder_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: sizing helpers, stage control payload and configuration check for cla_adder_pipe
// Used by: cla_adder_pipe (segment width, blocks per segment, parameter legality)
package cla_pkg;

   typedef struct packed {
      logic carry;
      logic sub;
      logic valid;
   } stage_ctl_t;

   function automatic int seg_w(input int width, input int stages);
      return width / stages;
   endfunction

   function automatic int blocks_per_seg(input int width, input int block, input int stages);
      return width / (block * stages);
   endfunction

   // Short-circuit order keeps the modulo and division away from zero divisors.
   function automatic bit cfg_ok(input int width, input int block, input int stages);
      return block >= 1 && stages >= 1 && (width % (block * stages)) == 0 && stages <= width / block;
   endfunction

endpackage

// File: rtl/cla_adder_pipe_block.sv
// cla_block_n: combinational BLOCK-bit generate/propagate carry-lookahead adder block
// Ports: a_i/b_i operands, c_i carry in, s_o sum, c_o carry out of the block
module cla_block_n #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a_i,
   input  logic [BLOCK-1:0] b_i,
   input  logic             c_i,
   output logic [BLOCK-1:0] s_o,
   output logic             c_o
);

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK:0]   c;
   logic             gg;
   logic             pp;

   assign g = a_i & b_i;
   assign p = a_i ^ b_i;

   // Every carry is a flat sum of products over g/p and c_i, not a ripple chain.
   always_comb begin
      c = '0;
      gg = 1'b0;
      pp = 1'b1;
      c[0] = c_i;
      for (int i = 0; i < BLOCK; i++) begin
         gg = 1'b0;
         pp = 1'b1;
         for (int j = i; j >= 0; j--) begin
            gg = gg | (pp & g[j]);
            pp = pp & p[j];
         end
         c[i+1] = gg | (pp & c_i);
      end
   end

   assign s_o = p ^ c[BLOCK-1:0];
   assign c_o = c[BLOCK];

endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder/subtractor, one segment per stage, valid/ready on both sides
// Ports: i_clk, i_rst_n (sync, active-low); i_valid/o_ready, i_a, i_b, i_carry_in, i_sub in;
//        o_valid/i_ready, o_s, o_carry_out out; o_overflow only with CLA_ADDER_PIPE_OVERFLOW_EN defined
module cla_adder_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int BLOCK  = 4,
   parameter int STAGES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry_in,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_s,
   output logic             o_carry_out
`ifdef CLA_ADDER_PIPE_OVERFLOW_EN
   ,output logic            o_overflow
`endif
);

   localparam int SEG = seg_w(WIDTH, STAGES);
   localparam int NB  = blocks_per_seg(WIDTH, BLOCK, STAGES);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] s;
      stage_ctl_t       ctl;
   } stage_t;

   stage_t d [STAGES];
   stage_t q [STAGES];
   logic   en;
   logic   unused_tail;

   if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_cfg
      $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK*STAGES and STAGES <= WIDTH/BLOCK");
   end

   // The whole pipe advances together; a full output stage blocks only while downstream stalls.
   assign en      = !o_valid || i_ready;
   assign o_ready = en;

`ifdef CLA_ADDER_PIPE_OVERFLOW_EN
   logic ovf_d;
   logic ovf_q;
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t          src;
      logic [NB:0]     gc;
      logic [SEG-1:0]  ss;
      // Stage 0 inverts B and forces the carry for subtraction, so later stages see a plain add.
      if (k == 0) begin : g_head
         assign src = '{a: i_a, b: i_sub ? ~i_b : i_b, s: '0,
                        ctl: '{carry: i_sub | i_carry_in, sub: i_sub, valid: i_valid}};
      end else begin : g_tail
         assign src = q[k-1];
      end
      assign gc[0] = src.ctl.carry;
      for (genvar j = 0; j < NB; j++) begin : g_blk
         cla_block_n #(.BLOCK(BLOCK)) u_blk (
            .a_i (src.a[k*SEG + j*BLOCK +: BLOCK]),
            .b_i (src.b[k*SEG + j*BLOCK +: BLOCK]),
            .c_i (gc[j]),
            .s_o (ss[j*BLOCK +: BLOCK]),
            .c_o (gc[j+1])
         );
      end
      // Slice k of src.s is still zero here, so OR-ing inserts this segment's sum.
      assign d[k] = '{a: src.a, b: src.b, s: src.s | (WIDTH'(ss) << (k*SEG)),
                      ctl: '{carry: gc[NB], sub: src.ctl.sub, valid: src.ctl.valid}};
`ifdef CLA_ADDER_PIPE_OVERFLOW_EN
      // Carry into the MSB is recovered as a^b^s at that bit.
      if (k == STAGES-1) begin : g_ovf
         assign ovf_d = src.a[WIDTH-1] ^ src.b[WIDTH-1] ^ ss[SEG-1] ^ gc[NB];
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < STAGES; i++) q[i] <= '0;
      end else if (en) begin
         q <= d;
      end
   end

`ifdef CLA_ADDER_PIPE_OVERFLOW_EN
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) ovf_q <= 1'b0;
      else if (en) ovf_q <= ovf_d;
   end
   assign o_overflow = ovf_q;
`endif

   assign o_valid     = q[STAGES-1].ctl.valid;
   assign o_s         = q[STAGES-1].s;
   assign o_carry_out = q[STAGES-1].ctl.carry;
   assign unused_tail = ^{q[STAGES-1].a, q[STAGES-1].b, q[STAGES-1].ctl.sub};

endmodule
